// File: rtl/ext_ram_blk_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ext_ram_blk_writer
//  Description : Write-side initiator for the 32-bit external frame RAM.
//                Queues reconstructed 4x4 Y/U/V blocks, computes planar
//                YUV 4:2:0 byte addresses and issues one word write per row.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_ram_blk_writer #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_of_frame,
    input  logic [2:0]        pic_num,
    input  logic [7:0]        pic_width_in_mbs_minus1,
    input  logic [7:0]        pic_height_in_map_units_minus1,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [1:0]        blk_comp,
    input  logic [7:0]        blk_x,
    input  logic [7:0]        blk_y,
    input  logic [127:0]      blk_data,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              write_to_ram_idle
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    // Address arithmetic never narrower than 26 bits, wider if the port is.
    localparam int CALC_W = (ADDR_W > 26) ? ADDR_W : 26;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WR0   = 3'd2,
        ST_WR1   = 3'd3,
        ST_WR2   = 3'd4,
        ST_WR3   = 3'd5
    } state_t;

    state_t r_state, r_ret, w_state_next, w_ret_next, w_drain_next;

    logic [7:0]        r_width_m1, r_height_m1;
    logic [2:0]        r_pic_num;
    logic [CALC_W-1:0] r_luma_size, r_frame_base;
    logic [12:0]       r_stride_y, r_stride_c;

    logic [ADDR_W-1:0] r_fifo_addr   [FIFO_DEPTH];
    logic [12:0]       r_fifo_stride [FIFO_DEPTH];
    logic [127:0]      r_fifo_data   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count, w_count_next;
    logic              r_started, r_idle;

    logic              w_full, w_accept, w_push, w_pop, w_writing;
    logic [1:0]        w_row;
    logic [12:0]       w_width_px, w_height_px, w_stride;
    logic [CALC_W-1:0] w_luma, w_frame_size, w_frame_base, w_plane_base, w_row0;

    // Frame geometry derived from the values latched at start_of_frame.
    assign w_width_px   = (13'(r_width_m1)  + 13'd1) << 4;
    assign w_height_px  = (13'(r_height_m1) + 13'd1) << 4;
    assign w_luma       = CALC_W'(w_width_px) * CALC_W'(w_height_px);
    assign w_frame_size = w_luma + (w_luma >> 1);
    assign w_frame_base = w_frame_size * CALC_W'(r_pic_num);

    // Handshake: ready is held off while geometry is being (re)computed.
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign blk_ready = r_started && !w_full && (r_state != ST_SETUP) && !start_of_frame;
    assign w_accept  = blk_valid && blk_ready;
    assign w_push    = w_accept && (blk_comp != 2'd3);
    assign w_pop     = (r_state == ST_WR3);

    // Row-0 address of the offered block from the current frame geometry.
    always_comb begin
        w_stride     = r_stride_c;
        w_plane_base = r_frame_base + r_luma_size + (r_luma_size >> 2);
        case (blk_comp)
            2'd0: begin
                w_stride     = r_stride_y;
                w_plane_base = r_frame_base;
            end
            2'd1: w_plane_base = r_frame_base + r_luma_size;
            default: ;
        endcase
        w_row0 = w_plane_base + CALC_W'({blk_y, 2'b00}) * CALC_W'(w_stride)
               + CALC_W'({blk_x, 2'b00});
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: ;
        endcase
    end

    // Next drain state; a frame start parks the drain for one SETUP cycle.
    always_comb begin
        w_drain_next = r_state;
        w_ret_next   = r_ret;
        case (r_state)
            ST_IDLE:  w_drain_next = (r_count != '0) ? ST_WR0 : ST_IDLE;
            ST_SETUP: w_drain_next = r_ret;
            ST_WR0:   w_drain_next = ST_WR1;
            ST_WR1:   w_drain_next = ST_WR2;
            ST_WR2:   w_drain_next = ST_WR3;
            ST_WR3:   w_drain_next = (w_count_next != '0) ? ST_WR0 : ST_IDLE;
            default:  w_drain_next = ST_IDLE;
        endcase
        if (start_of_frame) begin
            w_state_next = ST_SETUP;
            w_ret_next   = w_drain_next;
        end else begin
            w_state_next = w_drain_next;
        end
    end

    // State, pointers, geometry and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ret        <= ST_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_started    <= 1'b0;
            r_idle       <= 1'b1;
            r_width_m1   <= '0;
            r_height_m1  <= '0;
            r_pic_num    <= '0;
            r_luma_size  <= '0;
            r_frame_base <= '0;
            r_stride_y   <= '0;
            r_stride_c   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ret     <= w_ret_next;
            r_count   <= w_count_next;
            r_started <= 1'b1;
            r_idle    <= (w_count_next == '0) && !w_accept;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (start_of_frame) begin
                r_width_m1  <= pic_width_in_mbs_minus1;
                r_height_m1 <= pic_height_in_map_units_minus1;
                r_pic_num   <= pic_num;
            end
            if (r_state == ST_SETUP) begin
                r_luma_size  <= w_luma;
                r_frame_base <= w_frame_base;
                r_stride_y   <= w_width_px;
                r_stride_c   <= w_width_px >> 1;
            end
        end
    end

    // Entry storage; contents are only meaningful under the valid count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr]   <= w_row0[ADDR_W-1:0];
            r_fifo_stride[r_wptr] <= w_stride;
            r_fifo_data[r_wptr]   <= blk_data;
        end
    end

    // Row index of the write in progress.
    always_comb begin
        w_writing = 1'b1;
        w_row     = 2'd0;
        case (r_state)
            ST_WR0:  w_row = 2'd0;
            ST_WR1:  w_row = 2'd1;
            ST_WR2:  w_row = 2'd2;
            ST_WR3:  w_row = 2'd3;
            default: w_writing = 1'b0;
        endcase
    end

    assign wr                = w_writing;
    assign wr_addr           = w_writing ? (r_fifo_addr[r_rptr]
                               + ADDR_W'(r_fifo_stride[r_rptr]) * ADDR_W'(w_row)) : '0;
    assign wr_data           = w_writing ? r_fifo_data[r_rptr][{w_row, 5'b00000} +: 32] : '0;
    assign write_to_ram_idle = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_ext_ram_blk_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_ram_blk_writer
//  Description : Scoreboard bench for ext_ram_blk_writer. Expected writes are
//                queued from a frame-geometry model at accept time and popped
//                by an independent write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_ram_blk_writer;

    logic         clk = 1'b0;
    logic         rst, sof, valid;
    logic [2:0]   pic;
    logic [7:0]   wm1, hm1, bx, by;
    logic [1:0]   comp;
    logic [127:0] bdata;
    logic         blk_ready, wr, idle;
    logic [25:0]  wr_addr;
    logic [31:0]  wr_data;

    ext_ram_blk_writer #(.FIFO_DEPTH(2), .ADDR_W(26)) dut (
        .clk(clk), .rst(rst), .start_of_frame(sof), .pic_num(pic),
        .pic_width_in_mbs_minus1(wm1), .pic_height_in_map_units_minus1(hm1),
        .blk_valid(valid), .blk_ready(blk_ready), .blk_comp(comp),
        .blk_x(bx), .blk_y(by), .blk_data(bdata),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .write_to_ram_idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [25:0] a; logic [31:0] d; } exp_t;
    exp_t expq[$];
    int   checks = 0, failures = 0;
    int   wr_total = 0, last_wr_cyc = 0, stalls = 0;
    int   wr_log[$];

    // Reference frame geometry (zero after reset until a frame start).
    longint m_luma = 0, m_fb = 0, m_sy = 0, m_sc = 0;
    int     m_w = 0, m_h = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic model_geom(input int p, input int w, input int h);
        longint pw, ph;
        pw = (w + 1) * 16;
        ph = (h + 1) * 16;
        m_luma = pw * ph;
        m_fb   = (m_luma * 3 / 2) * p;
        m_sy   = pw;
        m_sc   = pw / 2;
        m_w = w; m_h = h;
    endtask

    task automatic model_push(input int c, input int x, input int y, input logic [127:0] d);
        longint base, st, a;
        exp_t   e;
        if (c == 3) return;
        if (c == 0)      begin base = m_fb;                    st = m_sy; end
        else if (c == 1) begin base = m_fb + m_luma;           st = m_sc; end
        else             begin base = m_fb + m_luma * 5 / 4;   st = m_sc; end
        for (int r = 0; r < 4; r++) begin
            a   = (base + (y * 4 + r) * st + x * 4) & 64'h3FF_FFFF;
            e.a = a[25:0];
            e.d = d[32*r +: 32];
            expq.push_back(e);
        end
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && wr === 1'b1) begin
            wr_total++;
            last_wr_cyc = cyc;
            wr_log.push_back(cyc);
            if (expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                e = expq.pop_front();
                check("wr_addr", {38'd0, wr_addr}, {38'd0, e.a});
                check("wr_data", {32'd0, wr_data}, {32'd0, e.d});
            end
        end
    end

    task automatic send(input int c, input int x, input int y, input logic [127:0] d, output int acc);
        bit done = 0;
        acc = -1;
        valid = 1'b1; comp = 2'(c); bx = 8'(x); by = 8'(y); bdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (blk_ready) begin
                acc = cyc; done = 1;
                model_push(c, x, y, d);
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic pulse_sof(input int p, input int w, input int h);
        sof = 1'b1; pic = 3'(p); wm1 = 8'(w); hm1 = 8'(h);
        @(negedge clk);
        check("ready_during_sof", {63'd0, blk_ready}, 64'd0);
        @(posedge clk); #1;
        sof = 1'b0;
        model_geom(p, w, h);
        @(negedge clk);
        check("ready_during_setup", {63'd0, blk_ready}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (idle && expq.size() == 0) ok = 1;
        end
        check("idle_reached", {63'd0, ok}, 64'd1);
        check("idle_one_after_last_wr", 64'(cyc - last_wr_cyc), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, n0;
        logic [127:0] d;
        rst = 1'b1; sof = 0; valid = 0; pic = 0; wm1 = 0; hm1 = 0;
        comp = 0; bx = 0; by = 0; bdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr", {63'd0, wr}, 64'd0);
        check("rst_wr_addr", {38'd0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_ready", {63'd0, blk_ready}, 64'd0);
        check("rst_idle", {63'd0, idle}, 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_reset", {63'd0, blk_ready}, 64'd1);
        check("idle_after_reset", {63'd0, idle}, 64'd1);
        @(posedge clk); #1;

        // Directed Y block with latency check
        pulse_sof(1, 1, 1);
        send(0, 2, 3, 128'h0F0E0D0C_0B0A0908_07060504_03020100, a);
        valid = 0;
        @(negedge clk);
        check("no_wr_at_accept_plus1", {63'd0, wr}, 64'd0);
        @(negedge clk);
        check("wr_at_accept_plus2", {63'd0, wr}, 64'd1);
        check("first_wr_addr_1928", {38'd0, wr_addr}, 64'd1928);
        @(posedge clk); #1;
        wait_idle();

        // Chroma planes
        send(1, 1, 1, 128'h1F1E1D1C_1B1A1918_17161514_13121110, a);
        send(2, 0, 0, 128'h2F2E2D2C_2B2A2928_27262524_23222120, a);
        valid = 0;
        wait_idle();

        // Illegal component: accepted, never written
        n0 = wr_total;
        send(3, 0, 0, {4{32'hDEADBEEF}}, a);
        valid = 0;
        repeat (6) @(negedge clk);
        check("comp3_no_writes", 64'(wr_total - n0), 64'd0);
        check("comp3_idle_back", {63'd0, idle}, 64'd1);
        @(posedge clk); #1;

        // Back-to-back blocks with valid held
        wr_log.delete(); stalls = 0;
        for (int k = 0; k < 3; k++)
            send(0, k, k, {$urandom, $urandom, $urandom, $urandom}, a);
        valid = 0;
        wait_idle();
        check("b2b_write_count", 64'(wr_log.size()), 64'd12);
        if (wr_log.size() == 12)
            check("b2b_no_bubble", 64'(wr_log[11] - wr_log[0]), 64'd11);
        check("ready_dropped_when_full", {63'd0, stalls > 0}, 64'd1);

        // Frame start while blocks are queued
        pulse_sof(0, 0, 0);
        send(0, 1, 1, {$urandom, $urandom, $urandom, $urandom}, a);
        send(1, 0, 0, {$urandom, $urandom, $urandom, $urandom}, a);
        valid = 0;
        pulse_sof(2, 0, 0);
        send(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, a);
        valid = 0;
        wait_idle();

        // Reset during WR2
        send(0, 1, 0, {$urandom, $urandom, $urandom, $urandom}, a);
        valid = 0;
        for (int i = 0; i < 20 && cyc < a + 4; i++) @(negedge clk);
        check("wr_before_midreset", {63'd0, wr}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_wr", {63'd0, wr}, 64'd0);
        check("midrst_idle", {63'd0, idle}, 64'd1);
        check("midrst_ready", {63'd0, blk_ready}, 64'd0);
        expq.delete();
        m_luma = 0; m_fb = 0; m_sy = 0; m_sc = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(1, 3, 5, d, a);
        valid = 0;
        wait_idle();

        // Randomized traffic with occasional mid-stream frame starts
        pulse_sof($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        for (int k = 0; k < 48; k++) begin
            int r, c, xm, ym;
            if (k % 13 == 12) begin
                valid = 0;
                pulse_sof($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            r  = $urandom_range(0, 9);
            c  = (r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            xm = (c == 0) ? (m_w + 1) * 4 : (m_w + 1) * 2;
            ym = (c == 0) ? (m_h + 1) * 4 : (m_h + 1) * 2;
            send(c, $urandom_range(0, xm - 1), $urandom_range(0, ym - 1),
                 {$urandom, $urandom, $urandom, $urandom}, a);
            if ($urandom_range(0, 2) == 0) begin
                valid = 0;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
        end
        valid = 0;
        wait_idle();
        check("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
